// File: rtl/usb_tfifo_arb_if.sv
// Requester-side and TFIFO-side signal bundle of the TFIFO write-port arbiter.
// slave: the arbiter; master: the requesters, TFIFO and status observer.
interface usb_tfifo_arb_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CNT_W = 10,
  parameter int unsigned ID_W  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              tfifo_wr;
  logic [7:0]        tfifo_wdata;
  logic              tfifo_full;
  logic              grant_active;
  logic [ID_W-1:0]   grant_id;
  logic [CNT_W-1:0]  pkt_cnt;
  logic              pkt_done;
  logic              pkt_err;

  modport slave (
    input  req_valid, req_data, req_last, tfifo_full,
    output req_ready, tfifo_wr, tfifo_wdata,
    output grant_active, grant_id, pkt_cnt, pkt_done, pkt_err
  );

  modport master (
    output req_valid, req_data, req_last, tfifo_full,
    input  req_ready, tfifo_wr, tfifo_wdata,
    input  grant_active, grant_id, pkt_cnt, pkt_done, pkt_err
  );
endinterface

// File: rtl/usb_tfifo_arb.sv
// Packet-level round-robin arbiter sharing the TFIFO write port among NREQ sources.
// Define USB_TFIFO_ARB_PRIO0_EN to give requester 0 fixed priority over the rest.
module usb_tfifo_arb #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned MAXPKT = 64,
  parameter int unsigned CNT_W  = 10,
  parameter int unsigned ID_W   = 2
) (
  input  logic clk_4xrate,
  input  logic rst0_async,
  input  logic flush,
  usb_tfifo_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  state_t           state_q, state_d;
  logic             active_q, active_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  rr_q, rr_d, rr_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             pick_found;
  logic [ID_W-1:0]  pick_id, scan_id, scan_base;
  logic             sel_valid, sel_last;
  logic [7:0]       sel_data;
  logic             beat;
  logic [NREQ-1:0]  req_ready_c;
  logic             tfifo_wr_c;
  logic [7:0]       tfifo_wdata_c;

  // Payload of the granted requester
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == ID_W'(i)) begin
        sel_valid = bus.req_valid[i];
        sel_last  = bus.req_last[i];
        sel_data  = bus.req_data[8*i +: 8];
      end
    end
  end

`ifdef USB_TFIFO_ARB_PRIO0_EN
  // Requester 0 wins outright; 1..NREQ-1 rotate, a pointer of 0 (reset/flush) acts as 1
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    scan_id    = '0;
    scan_base  = (rr_q == '0) ? ID_W'(1) : rr_q;
    if (bus.req_valid[0]) begin
      pick_found = 1'b1;
    end else begin
      for (int k = 0; k < NREQ - 1; k++) begin
        scan_id = ID_W'(32'd1 + ((32'(scan_base) - 32'd1 + 32'(k)) % (NREQ - 1)));
        if (!pick_found && bus.req_valid[scan_id]) begin
          pick_found = 1'b1;
          pick_id    = scan_id;
        end
      end
    end
  end

  assign rr_next = (grant_q == ID_W'(NREQ - 1)) ? ID_W'(1) : grant_q + ID_W'(1);
`else
  // First valid requester scanning upward from rr_q, modulo NREQ
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    scan_id    = '0;
    scan_base  = rr_q;
    for (int k = 0; k < NREQ; k++) begin
      scan_id = ID_W'((32'(scan_base) + 32'(k)) % NREQ);
      if (!pick_found && bus.req_valid[scan_id]) begin
        pick_found = 1'b1;
        pick_id    = scan_id;
      end
    end
  end

  assign rr_next = (grant_q == ID_W'(NREQ - 1)) ? '0 : grant_q + ID_W'(1);
`endif

  assign beat = (state_q == XFER) && active_q && sel_valid && !bus.tfifo_full && !flush;

  // Next-state, registered-field updates and the combinational datapath
  always_comb begin
    state_d       = state_q;
    active_d      = active_q;
    grant_d       = grant_q;
    rr_d          = rr_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    req_ready_c   = '0;
    tfifo_wr_c    = 1'b0;
    tfifo_wdata_c = '0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d  = XFER;
          active_d = 1'b1;
          grant_d  = pick_id;
          cnt_d    = '0;
        end
      end
      XFER: begin
        if (beat) begin
          req_ready_c   = NREQ'(1) << grant_q;
          tfifo_wr_c    = 1'b1;
          tfifo_wdata_c = sel_data;
          cnt_d         = cnt_q + CNT_W'(1);
          if (sel_last) begin
            state_d  = IDLE;
            active_d = 1'b0;
            rr_d     = rr_next;
            done_d   = 1'b1;
          end else if (cnt_q == CNT_W'(MAXPKT - 1)) begin
            state_d = DRAIN;
            err_d   = 1'b1;
          end
        end
      end
      DRAIN: begin
        // Overlength tail is swallowed without touching the TFIFO
        if (sel_valid && !flush) begin
          req_ready_c = NREQ'(1) << grant_q;
          if (sel_last) begin
            state_d  = IDLE;
            active_d = 1'b0;
            rr_d     = rr_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d  = IDLE;
      active_d = 1'b0;
      grant_d  = '0;
      rr_d     = '0;
      cnt_d    = '0;
      done_d   = 1'b0;
      err_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_4xrate or negedge rst0_async) begin
    if (!rst0_async) begin
      state_q  <= IDLE;
      active_q <= 1'b0;
      grant_q  <= '0;
      rr_q     <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.req_ready    = req_ready_c;
  assign bus.tfifo_wr     = tfifo_wr_c;
  assign bus.tfifo_wdata  = tfifo_wdata_c;
  assign bus.grant_active = active_q;
  assign bus.grant_id     = grant_q;
  assign bus.pkt_cnt      = cnt_q;
  assign bus.pkt_done     = done_q;
  assign bus.pkt_err      = err_q;

endmodule

// File: tb/tb_usb_tfifo_arb.sv
// Scoreboard bench for usb_tfifo_arb: requester queues feed the DUT, a negedge
// monitor checks writes, grants and packet events against expected queues.
module tb_usb_tfifo_arb;
  localparam int unsigned NREQ   = 4;
  localparam int unsigned MAXPKT = 64;
  localparam int unsigned CNT_W  = 10;
  localparam int unsigned ID_W   = 2;

  logic clk_4xrate = 1'b0;
  logic rst0_async = 1'b0;
  logic flush      = 1'b0;

  usb_tfifo_arb_if #(.NREQ(NREQ), .CNT_W(CNT_W), .ID_W(ID_W)) bus ();

  usb_tfifo_arb #(.NREQ(NREQ), .MAXPKT(MAXPKT), .CNT_W(CNT_W), .ID_W(ID_W)) dut (
    .clk_4xrate (clk_4xrate),
    .rst0_async (rst0_async),
    .flush      (flush),
    .bus        (bus)
  );

  always #5 clk_4xrate = ~clk_4xrate;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] src_q [NREQ][$];
  logic [7:0] exp_wr[$];
  int         exp_gnt[$];
  int         exp_evt[$];
  logic [NREQ-1:0] rdy_s = '0;
  logic            prev_active = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int evt_code(input bit err, input int cnt);
    return (err ? 4096 : 0) + cnt;
  endfunction

  task automatic add_src(input int i, input int n, input logic [7:0] base, input int inc);
    for (int k = 0; k < n; k++)
      src_q[i].push_back({(k == n - 1), 8'(int'(base) + k * inc)});
  endtask

  task automatic exp_pkt(input int i, input int n, input logic [7:0] base, input int inc);
    exp_gnt.push_back(i);
    for (int k = 0; k < n; k++) exp_wr.push_back(8'(int'(base) + k * inc));
  endtask

  task automatic step();
    @(posedge clk_4xrate);
    #2;
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < NREQ; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      step();
      ok = srcs_empty() && !bus.grant_active && exp_wr.size() == 0 && exp_evt.size() == 0;
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_cnt(input string name, input int cnt);
    bit ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      step();
      ok = bus.grant_active && (int'(bus.pkt_cnt) == cnt);
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  // Requester model: retire a byte consumed in the previous cycle, present the next
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(posedge clk_4xrate);
      #1;
      for (int i = 0; i < NREQ; i++)
        if (rdy_s[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
      for (int i = 0; i < NREQ; i++) begin
        if (src_q[i].size() != 0) begin
          bus.req_valid[i]        = 1'b1;
          bus.req_last[i]         = src_q[i][0][8];
          bus.req_data[8*i +: 8]  = src_q[i][0][7:0];
        end else begin
          bus.req_valid[i]        = 1'b0;
          bus.req_last[i]         = 1'b0;
          bus.req_data[8*i +: 8]  = 8'h00;
        end
      end
    end
  end

  // Monitor: compare everything the DUT presents against the expected queues
  always @(negedge clk_4xrate) begin
    logic [NREQ-1:0] allowed;
    if (rst0_async) begin
      rdy_s   = bus.req_ready;
      allowed = bus.grant_active ? (NREQ'(1) << bus.grant_id) : '0;
      chk("ready_mask", 32'(bus.req_ready & ~allowed), 32'd0);
      if (bus.tfifo_wr) begin
        if (exp_wr.size() == 0) chk("unexpected_wr", 32'(bus.tfifo_wdata), 32'hFFFF_FFFF);
        else chk("wdata", 32'(bus.tfifo_wdata), 32'(exp_wr.pop_front()));
      end else if (bus.tfifo_wdata !== 8'h00) begin
        chk("wdata_idle_zero", 32'(bus.tfifo_wdata), 32'd0);
      end
      if (bus.grant_active && !prev_active) begin
        if (exp_gnt.size() == 0) chk("unexpected_grant", 32'(bus.grant_id), 32'hFFFF_FFFF);
        else chk("grant_id", 32'(bus.grant_id), 32'(exp_gnt.pop_front()));
      end
      if (bus.pkt_done || bus.pkt_err) begin
        chk("done_err_exclusive", 32'(bus.pkt_done & bus.pkt_err), 32'd0);
        if (exp_evt.size() == 0) chk("unexpected_evt", 32'(evt_code(bus.pkt_err, int'(bus.pkt_cnt))), 32'hFFFF_FFFF);
        else chk("pkt_evt", 32'(evt_code(bus.pkt_err, int'(bus.pkt_cnt))), 32'(exp_evt.pop_front()));
      end
      prev_active = bus.grant_active;
    end else begin
      rdy_s       = '0;
      prev_active = 1'b0;
    end
  end

  initial begin
    bus.tfifo_full = 1'b0;

    // Reset values
    repeat (2) @(negedge clk_4xrate);
    chk("rst_grant_active", 32'(bus.grant_active), 32'd0);
    chk("rst_grant_id",     32'(bus.grant_id),     32'd0);
    chk("rst_pkt_cnt",      32'(bus.pkt_cnt),      32'd0);
    chk("rst_pkt_done",     32'(bus.pkt_done),     32'd0);
    chk("rst_pkt_err",      32'(bus.pkt_err),      32'd0);
    chk("rst_tfifo_wr",     32'(bus.tfifo_wr),     32'd0);
    chk("rst_req_ready",    32'(bus.req_ready),    32'd0);
    step();
    rst0_async = 1'b1;

    // Single 3-byte packet from req0
    add_src(0, 3, 8'h11, 8'h11);
    exp_pkt(0, 3, 8'h11, 8'h11);
    exp_evt.push_back(evt_code(1'b0, 3));
    wait_idle("single_idle");
    chk("idle_cnt_hold", 32'(bus.pkt_cnt), 32'd3);

    // Idle flush resets rr_ptr, then round-robin 0,1,2,3,0
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < NREQ; i++) add_src(i, 2, 8'(8'h80 + 16 * i), 1);
    add_src(0, 2, 8'hF0, 1);
    for (int i = 0; i < NREQ; i++) begin
      exp_pkt(i, 2, 8'(8'h80 + 16 * i), 1);
      exp_evt.push_back(evt_code(1'b0, 2));
    end
    exp_pkt(0, 2, 8'hF0, 1);
    exp_evt.push_back(evt_code(1'b0, 2));
    wait_idle("rr_idle");

    // Backpressure on byte 2 of a 4-byte packet from req1
    add_src(1, 4, 8'hA1, 1);
    exp_pkt(1, 4, 8'hA1, 1);
    exp_evt.push_back(evt_code(1'b0, 4));
    wait_cnt("bp_first_byte", 1);
    bus.tfifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_tfifo_wr",  32'(bus.tfifo_wr),  32'd0);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_pkt_cnt",   32'(bus.pkt_cnt),   32'd1);
      step();
    end
    bus.tfifo_full = 1'b0;
    wait_idle("bp_idle");

    // Overlength: 70 bytes from req1, only MAXPKT written, then req2 single byte
    add_src(1, 70, 8'h00, 1);
    exp_pkt(1, MAXPKT, 8'h00, 1);
    exp_evt.push_back(evt_code(1'b1, MAXPKT));
    wait_idle("ovl_idle");
    add_src(2, 1, 8'h55, 0);
    exp_pkt(2, 1, 8'h55, 0);
    exp_evt.push_back(evt_code(1'b0, 1));
    wait_idle("ovl_next_idle");

    // Flush after 10 bytes of req2; req1 then wins over the req2 remainder
    add_src(2, 20, 8'h40, 1);
    exp_pkt(2, 10, 8'h40, 1);
    wait_cnt("flush_ten_bytes", 10);
    flush = 1'b1;
    add_src(1, 2, 8'h60, 1);
    step();
    flush = 1'b0;
    #1;
    chk("flush_grant_active", 32'(bus.grant_active), 32'd0);
    chk("flush_pkt_cnt",      32'(bus.pkt_cnt),      32'd0);
    chk("flush_tfifo_wr",     32'(bus.tfifo_wr),     32'd0);
    exp_pkt(1, 2, 8'h60, 1);
    exp_evt.push_back(evt_code(1'b0, 2));
    exp_pkt(2, 10, 8'h4A, 1);
    exp_evt.push_back(evt_code(1'b0, 10));
    wait_idle("flush_idle");

    // req2 in flight, req0 and req3 arrive behind it
    add_src(2, 3, 8'hC0, 1);
    exp_pkt(2, 3, 8'hC0, 1);
    exp_evt.push_back(evt_code(1'b0, 3));
    wait_cnt("mix_grant", 0);
    add_src(0, 1, 8'hD0, 0);
    add_src(3, 1, 8'hE3, 0);
`ifdef USB_TFIFO_ARB_PRIO0_EN
    exp_pkt(0, 1, 8'hD0, 0);
    exp_evt.push_back(evt_code(1'b0, 1));
    exp_pkt(3, 1, 8'hE3, 0);
    exp_evt.push_back(evt_code(1'b0, 1));
`else
    exp_pkt(3, 1, 8'hE3, 0);
    exp_evt.push_back(evt_code(1'b0, 1));
    exp_pkt(0, 1, 8'hD0, 0);
    exp_evt.push_back(evt_code(1'b0, 1));
`endif
    wait_idle("mix_idle");
    add_src(3, 1, 8'hF3, 0);
    add_src(1, 1, 8'hF1, 0);
    exp_pkt(1, 1, 8'hF1, 0);
    exp_evt.push_back(evt_code(1'b0, 1));
    exp_pkt(3, 1, 8'hF3, 0);
    exp_evt.push_back(evt_code(1'b0, 1));
    wait_idle("tail_idle");

    repeat (3) step();
    chk("left_wr",  32'(exp_wr.size()),  32'd0);
    chk("left_gnt", 32'(exp_gnt.size()), 32'd0);
    chk("left_evt", 32'(exp_evt.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
